// File: rtl/core_launch_ctrl.sv
// Launch controller: starts a masked set of cores, collects their completions,
// and bounds the wait with an optional watchdog before reporting back.
module core_launch_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_en,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic                 ack,
    output logic [NUM_CORES-1:0] core_start,
    output logic [1:0]           phase,
    output logic [NUM_CORES-1:0] done_mask,
    output logic                 all_done,
    output logic                 timed_out,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE          = 2'b00,
        START_CORES   = 2'b01,
        WAIT_FOR_DONE = 2'b10,
        DONE_STATE    = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [TIMEOUT_W-1:0] lim_q, lim_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic [NUM_CORES-1:0] done_mask_q, done_mask_d;
    logic                 all_done_q, all_done_d;
    logic                 timed_out_q, timed_out_d;
    logic                 busy_q, busy_d;

    logic [NUM_CORES-1:0] merged;
    logic                 complete;
    logic                 expired;

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        lim_d        = lim_q;
        cnt_d        = cnt_q;
        core_start_d = '0;
        done_mask_d  = done_mask_q;
        all_done_d   = 1'b0;
        timed_out_d  = timed_out_q;
        merged       = done_mask_q | (core_done & mask_q);
        complete     = (merged == mask_q);
        expired      = (lim_q != '0) && (cnt_q == (lim_q - TIMEOUT_W'(1)));

        case (state_q)
            IDLE: begin
                if (start && (core_en != '0)) begin
                    state_d      = START_CORES;
                    mask_d       = core_en;
                    lim_d        = timeout_lim;
                    cnt_d        = '0;
                    core_start_d = core_en;
                    done_mask_d  = '0;
                    timed_out_d  = 1'b0;
                end
            end
            START_CORES: begin
                state_d = WAIT_FOR_DONE;
            end
            WAIT_FOR_DONE: begin
                done_mask_d = merged;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
                // Completion is tested first so it beats a same-cycle expiry.
                if (complete) begin
                    state_d    = DONE_STATE;
                    all_done_d = 1'b1;
                end else if (expired) begin
                    state_d     = DONE_STATE;
                    timed_out_d = 1'b1;
                end
            end
            DONE_STATE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == START_CORES) || (state_d == WAIT_FOR_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            lim_q        <= '0;
            cnt_q        <= '0;
            core_start_q <= '0;
            done_mask_q  <= '0;
            all_done_q   <= 1'b0;
            timed_out_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            lim_q        <= lim_d;
            cnt_q        <= cnt_d;
            core_start_q <= core_start_d;
            done_mask_q  <= done_mask_d;
            all_done_q   <= all_done_d;
            timed_out_q  <= timed_out_d;
            busy_q       <= busy_d;
        end
    end

    assign phase      = state_q;
    assign core_start = core_start_q;
    assign done_mask  = done_mask_q;
    assign all_done   = all_done_q;
    assign timed_out  = timed_out_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_core_launch_ctrl.sv
// Directed bench for core_launch_ctrl: a cycle-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_core_launch_ctrl;

    localparam int NC = 4;
    localparam int TW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NC-1:0] core_en;
    logic [TW-1:0] timeout_lim;
    logic [NC-1:0] core_done;
    logic          ack;
    logic [NC-1:0] core_start;
    logic [1:0]    phase;
    logic [NC-1:0] done_mask;
    logic          all_done;
    logic          timed_out;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model state, in plain integers.
    int m_phase;
    int m_mask;
    int m_lim;
    int m_waits;
    int m_done;
    int m_core_start;
    int m_all_done;
    int m_timed_out;

    core_launch_ctrl #(.NUM_CORES(NC), .TIMEOUT_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .core_en     (core_en),
        .timeout_lim (timeout_lim),
        .core_done   (core_done),
        .ack         (ack),
        .core_start  (core_start),
        .phase       (phase),
        .done_mask   (done_mask),
        .all_done    (all_done),
        .timed_out   (timed_out),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model steps on each rising edge using the same inputs the DUT samples.
    always @(posedge clk) begin
        m_core_start = 0;
        m_all_done   = 0;
        if (rst) begin
            m_phase = 0; m_mask = 0; m_lim = 0; m_waits = 0;
            m_done = 0; m_timed_out = 0;
        end else begin
            case (m_phase)
                0: if (start && core_en != 0) begin
                    m_phase = 1; m_mask = int'(core_en); m_lim = int'(timeout_lim);
                    m_waits = 0; m_done = 0; m_timed_out = 0; m_core_start = int'(core_en);
                end
                1: m_phase = 2;
                2: begin
                    m_waits = m_waits + 1;
                    m_done  = m_done | (int'(core_done) & m_mask);
                    if (m_done == m_mask) begin
                        m_phase = 3; m_all_done = 1;
                    end else if (m_lim != 0 && m_waits >= m_lim) begin
                        m_phase = 3; m_timed_out = 1;
                    end
                end
                default: if (ack) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("phase",      32'(phase),      32'(m_phase));
            check_output("core_start", 32'(core_start), 32'(m_core_start));
            check_output("done_mask",  32'(done_mask),  32'(m_done));
            check_output("all_done",   32'(all_done),   32'(m_all_done));
            check_output("timed_out",  32'(timed_out),  32'(m_timed_out));
            check_output("busy",       32'(busy),       32'((m_phase == 1) || (m_phase == 2)));
        end
    end

    // Drive one cycle of inputs, then return just after the edge that used them.
    task automatic apply_stimulus(input logic r, input logic st, input logic [NC-1:0] en,
                                  input logic [TW-1:0] lim, input logic [NC-1:0] dn, input logic ak);
        rst = r; start = st; core_en = en; timeout_lim = lim; core_done = dn; ack = ak;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; core_en = '0; timeout_lim = '0; core_done = '0; ack = 1'b0;
        #1;

        // Reset values
        apply_stimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'b1111, 16'd3, 4'b1111, 1'b1);
        check_output("rst_phase", 32'(phase), 32'h0);
        check_output("rst_core_start", 32'(core_start), 32'h0);
        check_output("rst_done_mask", 32'(done_mask), 32'h0);
        check_output("rst_flags", 32'({all_done, timed_out, busy}), 32'h0);
        cmp_en = 1'b1;

        // All four cores, no watchdog, staggered completions
        apply_stimulus(1'b0, 1'b1, 4'b1111, 16'd0, 4'b1111, 1'b0);
        check_output("s1_phase_start", 32'(phase), 32'h1);
        check_output("s1_core_start", 32'(core_start), 32'hF);
        check_output("s1_busy", 32'(busy), 32'h1);
        idle_cycle();
        check_output("s1_phase_wait", 32'(phase), 32'h2);
        check_output("s1_core_start_off", 32'(core_start), 32'h0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0001, 1'b0);
        check_output("s1_mask_a", 32'(done_mask), 32'h1);
        apply_stimulus(1'b0, 1'b1, 4'b0001, '0, 4'b0100, 1'b1);
        check_output("s1_mask_b", 32'(done_mask), 32'h5);
        apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0010, 1'b0);
        check_output("s1_mask_c", 32'(done_mask), 32'h7);
        check_output("s1_still_wait", 32'(phase), 32'h2);
        apply_stimulus(1'b0, 1'b0, '0, '0, 4'b1000, 1'b0);
        check_output("s1_phase_done", 32'(phase), 32'h3);
        check_output("s1_all_done", 32'(all_done), 32'h1);
        idle_cycle();
        check_output("s1_all_done_pulse", 32'(all_done), 32'h0);
        apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check_output("s1_back_idle", 32'(phase), 32'h0);
        check_output("s1_mask_persist", 32'(done_mask), 32'hF);

        // Watchdog expiry after ten WAIT cycles
        apply_stimulus(1'b0, 1'b1, 4'b0101, 16'd10, '0, 1'b0);
        idle_cycle();
        for (int i = 0; i < 9; i++) idle_cycle();
        check_output("s2_wait_before_expiry", 32'(phase), 32'h2);
        idle_cycle();
        check_output("s2_phase_done", 32'(phase), 32'h3);
        check_output("s2_timed_out", 32'(timed_out), 32'h1);
        check_output("s2_no_all_done", 32'(all_done), 32'h0);
        check_output("s2_done_mask", 32'(done_mask), 32'h0);
        apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);
        check_output("s2_to_persists", 32'(timed_out), 32'h1);

        // Completion in the expiry cycle wins
        apply_stimulus(1'b0, 1'b1, 4'b0011, 16'd5, '0, 1'b0);
        check_output("s3_to_cleared", 32'(timed_out), 32'h0);
        idle_cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) idle_cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0010, 1'b0);
        check_output("s3_all_done", 32'(all_done), 32'h1);
        check_output("s3_timed_out", 32'(timed_out), 32'h0);
        apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);

        // Unmasked completions ignored; ack with start returns to IDLE only
        apply_stimulus(1'b0, 1'b1, 4'b0001, 16'd0, '0, 1'b0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 4'b1111, 1'b0);
        check_output("s4_start_done_ignored", 32'(done_mask), 32'h0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, '0, '0, 4'b1110, 1'b1);
        check_output("s4_unmasked_ignored", 32'(done_mask), 32'h0);
        check_output("s4_ack_ignored", 32'(phase), 32'h2);
        apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0001, 1'b0);
        check_output("s4_phase_done", 32'(phase), 32'h3);
        apply_stimulus(1'b0, 1'b1, 4'b1111, '0, '0, 1'b1);
        check_output("s4_ack_idle", 32'(phase), 32'h0);
        idle_cycle();
        check_output("s4_start_with_ack_ignored", 32'(phase), 32'h0);

        // Watchdog limit of one
        apply_stimulus(1'b0, 1'b1, 4'b0001, 16'd1, '0, 1'b0);
        idle_cycle();
        idle_cycle();
        check_output("s5_lim1_timed_out", 32'(timed_out), 32'h1);
        apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1);

        // Reset mid-WAIT, then start with an empty mask
        apply_stimulus(1'b0, 1'b1, 4'b0111, 16'd0, '0, 1'b0);
        idle_cycle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0011, 1'b0);
        check_output("s6_mask_partial", 32'(done_mask), 32'h3);
        apply_stimulus(1'b1, 1'b0, '0, '0, 4'b0100, 1'b0);
        check_output("s6_rst_phase", 32'(phase), 32'h0);
        check_output("s6_rst_mask", 32'(done_mask), 32'h0);
        check_output("s6_rst_busy", 32'(busy), 32'h0);
        apply_stimulus(1'b0, 1'b1, 4'b0000, 16'd4, '0, 1'b0);
        idle_cycle();
        check_output("s6_empty_start", 32'(phase), 32'h0);

        // Reset during START_CORES
        apply_stimulus(1'b0, 1'b1, 4'b1010, 16'd0, '0, 1'b0);
        apply_stimulus(1'b1, 1'b0, '0, '0, '0, 1'b0);
        check_output("s7_rst_in_start", 32'({phase, core_start}), 32'h0);
        idle_cycle();

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_launch_ctrl.md
CORE_LAUNCH_CTRL -- requirements
Module: core_launch_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, giving the number of cores controlled (legal range 1..8).
REQ-002 The block SHALL have parameter TIMEOUT_W, default 16, giving the watchdog counter width.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  launch request; sampled only in IDLE.
REQ-006 Port core_en  input  NUM_CORES  mask of cores to launch; captured with start.
REQ-007 Port timeout_lim  input  TIMEOUT_W  watchdog limit in WAIT cycles; captured with start; 0 disables the watchdog.
REQ-008 Port core_done  input  NUM_CORES  per-core completion indication (pulse or level).
REQ-009 Port ack  input  1  releases DONE_STATE back to IDLE.
REQ-010 Port core_start  output  NUM_CORES  one-cycle per-core launch pulse.
REQ-011 Port phase  output  2  state code (00 IDLE, 01 START_CORES, 10 WAIT_FOR_DONE, 11 DONE_STATE), driving the downstream GPIO LED stage.
REQ-012 Port done_mask  output  NUM_CORES  sticky per-core completion flags.
REQ-013 Port all_done  output  1  one-cycle pulse on successful completion.
REQ-014 Port timed_out  output  1  sticky watchdog-expiry flag.
REQ-015 Port busy  output  1  high in START_CORES and WAIT_FOR_DONE.

Function
REQ-016 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-017 IDLE: on start=1 with core_en!=0, the block SHALL capture core_en and timeout_lim and enter START_CORES on the next edge; start with core_en=0 SHALL be ignored.
REQ-018 START_CORES SHALL last exactly one cycle, with core_start = captured mask, done_mask=0, watchdog counter=0 and timed_out=0; it SHALL then enter WAIT_FOR_DONE.
REQ-019 core_start SHALL be 0 in every state other than START_CORES.
REQ-020 core_done SHALL be ignored in START_CORES and for cores not in the captured mask.
REQ-021 WAIT_FOR_DONE: each cycle, done_mask SHALL be updated to done_mask | (core_done & mask).
REQ-022 When (done_mask | (core_done & mask)) == mask, the block SHALL enter DONE_STATE on that edge and pulse all_done for exactly the first DONE_STATE cycle.
REQ-023 The watchdog counter SHALL increment once per WAIT_FOR_DONE cycle and saturate at all-ones.
REQ-024 If timeout_lim!=0 and counter == timeout_lim-1 without completion, the block SHALL set timed_out and enter DONE_STATE with no all_done pulse.
REQ-025 If completion and expiry occur in the same cycle, completion SHALL win: all_done pulses and timed_out stays 0.
REQ-026 DONE_STATE SHALL hold done_mask and timed_out until ack=1, then return to IDLE on the next edge; done_mask and timed_out SHALL persist in IDLE until the next START_CORES.
REQ-027 ack outside DONE_STATE and start outside IDLE SHALL be ignored; start in the same cycle as ack in DONE_STATE SHALL be ignored.
REQ-028 phase SHALL equal the current state code every cycle.

Reset
REQ-029 While rst=1, the block SHALL set phase=IDLE and core_start=0, done_mask=0, all_done=0, timed_out=0, busy=0, clear the captured mask, limit and counter, and override all other inputs.
REQ-030 Reset asserted in any state, including mid-WAIT_FOR_DONE, SHALL yield the REQ-029 values on the next edge with no core_start pulse and no all_done pulse.

Verification
REQ-031 NUM_CORES=4, start with core_en=4'b1111, lim=0, then done pulses on cores 0,2,1,3 in separate cycles -> phase 00->01->10; core_start=1111 for 1 cycle; done_mask accumulates; phase=11 and all_done pulses once on the edge after core 3.
REQ-032 core_en=4'b0101, lim=10, no core_done -> after 10 WAIT cycles timed_out=1, phase=11, all_done never asserts, done_mask=0000.
REQ-033 core_en=4'b0011, lim=5; core 0 done early, core 1 done in the 5th WAIT cycle -> all_done=1, timed_out=0 (completion wins).
REQ-034 core_en=4'b0001; core_done=4'b1110 held -> remains in WAIT with done_mask=0000; core 0 done -> DONE; ack=1 -> IDLE next cycle.
REQ-035 rst=1 mid-WAIT with done_mask=0011 -> next cycle phase=00, done_mask=0000, busy=0; start with core_en=0000 -> phase stays 00.
